// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the response buffer state type.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

    // Opcodes at or above this value are illegal.
    localparam logic [ALU_OP_W-1:0] ALU_ILLEGAL_FIRST = 4'd10;

    // Response buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [XLEN-1:0]     y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Opcode decode and result selection.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end sharing one ALU, with a single registered
// response buffer and saturating per-port grant counters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Ready may depend on valid; valid never depends on ready, and
// a requester holds valid and payload stable until it sees ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [XLEN-1:0]     req0_a,
    input  logic [XLEN-1:0]     req0_b,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [TAG_W-1:0]    req0_tag,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [XLEN-1:0]     req1_a,
    input  logic [XLEN-1:0]     req1_b,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [TAG_W-1:0]    req1_tag,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_id,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err,

    output logic [CNT_W-1:0]    grant_cnt0,
    output logic [CNT_W-1:0]    grant_cnt1
);

    buf_state_t          buf_state;
    logic                last_grant;
    logic                grant_sel;
    logic                can_accept;
    logic                accept;
    logic [XLEN-1:0]     sel_a;
    logic [XLEN-1:0]     sel_b;
    logic [ALU_OP_W-1:0] sel_op;
    logic [TAG_W-1:0]    sel_tag;
    logic [XLEN-1:0]     alu_y;

    // Round-robin pick: a lone requester wins; on a tie the port that did
    // not win last time goes first.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    assign can_accept = (buf_state == BUF_EMPTY) || rsp_ready;
    assign req0_ready = req0_valid && !grant_sel && can_accept;
    assign req1_ready = req1_valid &&  grant_sel && can_accept;
    assign accept     = req0_ready || req1_ready;
    assign rsp_valid  = (buf_state == BUF_FULL);

    // Steer the granted port's operands into the shared ALU.
    always_comb begin
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_op  = req0_op;
        sel_tag = req0_tag;
        if (grant_sel) begin
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_op  = req1_op;
            sel_tag = req1_tag;
        end
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (alu_y)
    );

    // Buffer FSM, response registers, arbitration history and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_state  <= BUF_EMPTY;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            buf_state  <= BUF_FULL;
            rsp_data   <= alu_y;
            rsp_id     <= grant_sel;
            rsp_tag    <= sel_tag;
            rsp_err    <= (sel_op >= ALU_ILLEGAL_FIRST);
            last_grant <= grant_sel;
            if (!grant_sel && grant_cnt0 != '1) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (grant_sel && grant_cnt1 != '1) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end else if (buf_state == BUF_FULL && rsp_ready) begin
            buf_state <= BUF_EMPTY;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [63:0] req0_a, req0_b;
    logic [3:0]  req0_op;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready;
    logic [63:0] req1_a, req1_b;
    logic [3:0]  req1_op;
    logic [3:0]  req1_tag;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic [31:0] grant_cnt0, grant_cnt1;

    int n_cmp;
    int n_fail;

    logic [3:0]  v_op  [9];
    logic [63:0] v_a   [9];
    logic [63:0] v_b   [9];
    logic [63:0] v_y   [9];
    logic        v_err [9];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter #(
        .XLEN  (64),
        .TAG_W (4),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tag);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tag);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        drive1(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        #12;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%0b exp=0", rsp_id); end
        n_cmp++; if (rsp_tag !== 4'd0) begin n_fail++; $display("FAIL reset_rsp_tag got=%0d exp=0", rsp_tag); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
        n_cmp++; if (grant_cnt0 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt0 got=%0d exp=0", grant_cnt0); end
        n_cmp++; if (grant_cnt1 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt1 got=%0d exp=0", grant_cnt1); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b%0b exp=00", req0_ready, req1_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Both ports valid from reset: port 0 first, then strict alternation.
    task automatic test_round_robin();
        logic exp_id;
        logic [63:0] exp_d;
        drive0(1'b1, 4'd1, 64'd10, 64'd4, 4'd1);
        drive1(1'b1, 4'd4, 64'hF0, 64'h0F, 4'd2);
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            exp_d  = exp_id ? 64'hFF : 64'd6;
            #1;
            n_cmp++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin n_fail++; $display("FAIL rr_ready[%0d] got=%0b%0b exp_id=%0b", i, req0_ready, req1_ready, exp_id); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_d) begin n_fail++; $display("FAIL rr_rsp[%0d] got v=%0b id=%0b d=%h exp id=%0b d=%h", i, rsp_valid, rsp_id, rsp_data, exp_id, exp_d); end
            n_cmp++; if (rsp_tag !== (exp_id ? 4'd2 : 4'd1)) begin n_fail++; $display("FAIL rr_tag[%0d] got=%0d", i, rsp_tag); end
        end
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        drive1(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (grant_cnt0 !== 32'd2 || grant_cnt1 !== 32'd2) begin n_fail++; $display("FAIL rr_counts got=%0d/%0d exp=2/2", grant_cnt0, grant_cnt1); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_single();
        drive0(1'b1, 4'd0, 64'd5, 64'd3, 4'd7);
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got=%0b%0b exp=10", req0_ready, req1_ready); end
        step();
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd8 || rsp_id !== 1'b0 || rsp_tag !== 4'd7 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL single_rsp got v=%0b d=%0d id=%0b tag=%0d err=%0b exp 1/8/0/7/0", rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err); end
        n_cmp++; if (grant_cnt0 !== 32'd3) begin n_fail++; $display("FAIL single_cnt0 got=%0d exp=3", grant_cnt0); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 64'd8) begin n_fail++; $display("FAIL single_drain got v=%0b d=%0d exp v=0 d=8", rsp_valid, rsp_data); end
    endtask

    // last_grant is 0 here, so the tie after the stall goes to port 1.
    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive0(1'b1, 4'd0, 64'd1, 64'd1, 4'd3);
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready got=%0b exp=1", req0_ready); end
        step();
        drive0(1'b1, 4'd2, 64'd12, 64'd10, 4'd4);
        drive1(1'b1, 4'd3, 64'd12, 64'd3, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got=%0b%0b exp=00", i, req0_ready, req1_ready); end
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd2 || rsp_tag !== 4'd3) begin n_fail++; $display("FAIL bp_stall_rsp[%0d] got v=%0b d=%0d tag=%0d exp 1/2/3", i, rsp_valid, rsp_data, rsp_tag); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%0b%0b exp=01", req0_ready, req1_ready); end
        step();
        drive1(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd15 || rsp_id !== 1'b1 || rsp_tag !== 4'd5) begin n_fail++; $display("FAIL bp_rsp1 got v=%0b d=%0d id=%0b tag=%0d exp 1/15/1/5", rsp_valid, rsp_data, rsp_id, rsp_tag); end
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_port0_ready got=%0b exp=1", req0_ready); end
        step();
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (rsp_data !== 64'd8 || rsp_id !== 1'b0 || rsp_tag !== 4'd4) begin n_fail++; $display("FAIL bp_rsp0 got d=%0d id=%0b tag=%0d exp 8/0/4", rsp_data, rsp_id, rsp_tag); end
        n_cmp++; if (grant_cnt0 !== 32'd5 || grant_cnt1 !== 32'd3) begin n_fail++; $display("FAIL bp_counts got=%0d/%0d exp=5/3", grant_cnt0, grant_cnt1); end
        step();
    endtask

    // Back-to-back port 0 requests covering compares, shifts, wrap and illegal ops.
    task automatic test_ops();
        v_op[0] = 4'd8; v_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; v_b[0] = 64'd1; v_y[0] = 64'd1;                 v_err[0] = 1'b0;
        v_op[1] = 4'd9; v_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; v_b[1] = 64'd1; v_y[1] = 64'd0;                 v_err[1] = 1'b0;
        v_op[2] = 4'd7; v_a[2] = 64'h8000_0000_0000_0000; v_b[2] = 64'd4; v_y[2] = 64'hF800_0000_0000_0000; v_err[2] = 1'b0;
        v_op[3] = 4'd6; v_a[3] = 64'h8000_0000_0000_0000; v_b[3] = 64'd4; v_y[3] = 64'h0800_0000_0000_0000; v_err[3] = 1'b0;
        v_op[4] = 4'd5; v_a[4] = 64'd1;                   v_b[4] = 64'd35; v_y[4] = 64'd8;                v_err[4] = 1'b0;
        v_op[5] = 4'd0; v_a[5] = 64'hFFFF_FFFF_FFFF_FFFF; v_b[5] = 64'd1; v_y[5] = 64'd0;                 v_err[5] = 1'b0;
        v_op[6] = 4'hC; v_a[6] = 64'd5;                   v_b[6] = 64'd3; v_y[6] = 64'd0;                 v_err[6] = 1'b1;
        v_op[7] = 4'hA; v_a[7] = 64'd5;                   v_b[7] = 64'd3; v_y[7] = 64'd0;                 v_err[7] = 1'b1;
        v_op[8] = 4'hF; v_a[8] = 64'd5;                   v_b[8] = 64'd3; v_y[8] = 64'd0;                 v_err[8] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive0(1'b1, v_op[i], v_a[i], v_b[i], 4'(i));
            #1;
            n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ops_ready[%0d] got=%0b exp=1", i, req0_ready); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== v_y[i] || rsp_err !== v_err[i] || rsp_tag !== 4'(i))
                begin n_fail++; $display("FAIL ops_rsp[%0d] op=%0d got d=%h err=%0b tag=%0d exp d=%h err=%0b", i, v_op[i], rsp_data, rsp_err, rsp_tag, v_y[i], v_err[i]); end
        end
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (grant_cnt0 !== 32'd14) begin n_fail++; $display("FAIL ops_cnt0 got=%0d exp=14", grant_cnt0); end
        step();
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b0;
        drive0(1'b1, 4'd0, 64'd20, 64'd22, 4'd9);
        step();
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd42) begin n_fail++; $display("FAIL areset_pre got v=%0b d=%0d exp 1/42", rsp_valid, rsp_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 || rsp_tag !== 4'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL areset_rsp got v=%0b d=%0d tag=%0d id=%0b err=%0b exp all 0", rsp_valid, rsp_data, rsp_tag, rsp_id, rsp_err); end
        n_cmp++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin n_fail++; $display("FAIL areset_counts got=%0d/%0d exp=0/0", grant_cnt0, grant_cnt1); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        drive0(1'b1, 4'd4, 64'd6, 64'd3, 4'd1);
        drive1(1'b1, 4'd0, 64'd6, 64'd3, 4'd2);
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL areset_tie got=%0b%0b exp=10", req0_ready, req1_ready); end
        step();
        drive0(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        drive1(1'b0, 4'd0, 64'd0, 64'd0, 4'd0);
        n_cmp++; if (rsp_id !== 1'b0 || rsp_data !== 64'd5 || grant_cnt0 !== 32'd1 || grant_cnt1 !== 32'd0)
            begin n_fail++; $display("FAIL areset_first got id=%0b d=%0d cnt=%0d/%0d exp 0/5/1/0", rsp_id, rsp_data, grant_cnt0, grant_cnt1); end
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_ops();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
